cr_byte_stuffer: RTL and testbench
==================================

Name: cr_byte_stuffer

Overview:
- Downstream of the Cr Huffman encoder.
- Accepts 32-bit MSB-first bitstream words plus one end-of-block residual word per block.
- Buffers them in a small word FIFO and serialises them into bytes with a valid/ready handshake.
- Inserts the JPEG stuffing byte 0x00 after every emitted 0xFF. Pads the final partial byte of a block with 1s.

Parameters:
- FIFO_DEPTH, 4, number of word entries buffered; a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- data_ready  in  1  JPEG_bitstream holds a full 32-bit word this cycle
- JPEG_bitstream  in  32  full bitstream word; bit 31 is sent first
- eob_flush  in  1  end of block; residual bits are on flush_bits
- flush_bits  in  32  residual bits, MSB-aligned
- flush_count  in  5  number of valid residual bits, 0..31
- byte_ready  in  1  downstream accepts byte_out
- byte_out  out  8  output byte
- byte_valid  out  1  byte_out is valid
- block_done  out  1  one-cycle pulse when the last byte of a block (including its stuff byte) is accepted
- overflow  out  1  sticky; a write was dropped because the FIFO was full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset (also mid-operation): FIFO emptied, FSM to IDLE, byte index 0.
  - byte_out=0x00, byte_valid=0, block_done=0, overflow=0, fifo_count=0.
  - Any in-flight byte or stuff byte is discarded.
- FIFO entry contents: {word[31:0], nbytes[2:0] (1..4), last_of_block}.
- data_ready: writes {JPEG_bitstream, 4, 0}.
- eob_flush with flush_count=N>0:
  - Writes nbytes=ceil(N/8) and last_of_block=1.
  - Word = flush_bits with bits [31-N:0] forced to 1.
- eob_flush with N=0:
  - Writes no entry. If the FIFO is non-empty, marks the newest entry last_of_block=1.
  - Otherwise pulses block_done on the next cycle.
- Simultaneous data_ready and eob_flush: the data word is written first, the flush entry second, both in the same cycle.
  - Needs 2 free slots. If only 1 slot is free, the data word is kept, the flush entry is dropped and overflow is set.
- Any write into a full FIFO is dropped and overflow=1. overflow stays set until rst.
- A read and a write in the same cycle on a full FIFO is legal. The pop frees the slot first.
- Latency: an entry written at edge k into an empty FIFO gives byte_valid=1 with byte_out = word[31:24] after edge k+1.
- FSM:
  - IDLE: FIFO empty, byte_valid=0. Go to SEND when the FIFO is non-empty.
  - SEND: byte_out = head word byte at index idx (idx 0 = bits 31:24), byte_valid=1.
    - On byte_valid&&byte_ready with byte_out==0xFF: go to STUFF.
    - Otherwise idx++.
    - If idx reaches nbytes-1: pop the entry, set idx=0, go to SEND if more data remains, else IDLE.
  - STUFF: byte_out=0x00, byte_valid=1.
    - On accept: continue as for a non-FF byte (idx++ or pop).
- block_done: pulses in the cycle after the final accepted byte of a last_of_block entry. If that byte was 0xFF, the pulse follows acceptance of its 0x00.
- Byte outputs are registered. byte_out and byte_valid hold stable while byte_valid=1 and byte_ready=0.
- fifo_count decrements in the cycle after the pop edge.

Test Plan:
- Reset, then a single data_ready with word 0x12345678, byte_ready=1 → bytes 12,34,56,78 on consecutive cycles, first byte one cycle after the write; fifo_count returns to 0.
- Word 0xFF00FFAB → bytes FF,00,00,FF,00,AB (a stuff byte after each FF).
- eob_flush, flush_bits=0xA0000000, flush_count=3 → single byte 0xBF, then a block_done pulse. Also flush_count=8 with 0xFF000000 → FF,00, with block_done after the 00.
- Hold byte_ready=0 and issue 5 data_ready writes with FIFO_DEPTH=4 → fifo_count=4, overflow=1. Release byte_ready → exactly 16 data bytes from the first 4 words.
- data_ready (0x11223344) together with eob_flush (0xC0000000, count 2) → bytes 11,22,33,44,FF,00; block_done after the 00.
- Assert rst while a 0xFF is waiting to be stuffed → next cycle byte_valid=0, fifo_count=0. A following word 0x01020304 emits cleanly with no stray 00.

Source files
------------

// File: rtl/cr_byte_stuffer.sv
// JPEG byte stuffer for the Cr Huffman path: buffers 32-bit MSB-first words,
// serialises them to bytes, inserts 0x00 after every 0xFF and pads block tails with 1s.
module cr_byte_stuffer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_ready,
  input  logic [31:0]                   JPEG_bitstream,
  input  logic                          eob_flush,
  input  logic [31:0]                   flush_bits,
  input  logic [4:0]                    flush_count,
  input  logic                          byte_ready,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  output logic                          block_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } state_t;

  logic [31:0]   word_mem [FIFO_DEPTH];
  logic [2:0]    nb_mem   [FIFO_DEPTH];
  logic          last_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  state_t        state;
  logic [1:0]    idx;

  logic [31:0]   flush_word;
  logic [2:0]    flush_nb;
  logic          want_flush;
  logic          zero_flush;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] n_wr;
  logic [CW-1:0] count_next;
  logic          do_data;
  logic          do_flush;
  logic          ovf_set;
  logic          mark_tail;
  logic          zero_done;

  logic [31:0]   head_word;
  logic [2:0]    head_nb;
  logic          head_last;
  logic [31:0]   next_word;
  logic          accept;
  logic          need_stuff;
  logic          advance;
  logic          last_idx;
  logic          pop;

  assign fifo_count = count;

  // Residual bits are MSB-aligned; everything below them becomes 1-padding.
  assign flush_word = flush_bits | (ONES >> flush_count);
  assign flush_nb   = {1'b0, flush_count[4:3]} + {2'b00, |flush_count[2:0]};
  assign want_flush = eob_flush && (flush_count != 5'd0);
  assign zero_flush = eob_flush && (flush_count == 5'd0);

  assign head_word = word_mem[rd_ptr];
  assign head_nb   = nb_mem[rd_ptr];
  assign head_last = last_mem[rd_ptr];
  assign next_word = word_mem[rd_ptr + AW'(1)];

  assign accept     = byte_valid && byte_ready;
  assign need_stuff = (state == SEND) && (byte_out == 8'hFF);
  assign advance    = accept && ((state == STUFF) || ((state == SEND) && (byte_out != 8'hFF)));
  assign last_idx   = ({1'b0, idx} == (head_nb - 3'd1));
  assign pop        = advance && last_idx;

  // A pop in the same cycle frees its slot before the writes are placed.
  assign free_slots = CW'(FIFO_DEPTH) - count + CW'(pop);

  always_comb begin
    do_data  = 1'b0;
    do_flush = 1'b0;
    ovf_set  = 1'b0;
    if (data_ready && want_flush) begin
      if (free_slots >= CW'(2)) begin
        do_data  = 1'b1;
        do_flush = 1'b1;
      end else if (free_slots == CW'(1)) begin
        do_data = 1'b1;
        ovf_set = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (data_ready) begin
      if (free_slots != '0) do_data = 1'b1;
      else                  ovf_set = 1'b1;
    end else if (want_flush) begin
      if (free_slots != '0) do_flush = 1'b1;
      else                  ovf_set  = 1'b1;
    end
  end

  assign n_wr       = CW'(do_data) + CW'(do_flush);
  assign count_next = count + n_wr - CW'(pop);
  assign mark_tail  = zero_flush && (count_next != '0);
  assign zero_done  = zero_flush && (count_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_data) begin
        word_mem[wr_ptr] <= JPEG_bitstream;
        nb_mem[wr_ptr]   <= 3'd4;
        last_mem[wr_ptr] <= mark_tail;
      end
      if (do_flush) begin
        word_mem[wr_ptr + AW'(do_data)] <= flush_word;
        nb_mem[wr_ptr + AW'(do_data)]   <= flush_nb;
        last_mem[wr_ptr + AW'(do_data)] <= 1'b1;
      end
      // Zero-length flush closes the block on the newest entry already queued.
      if (mark_tail && !do_data) begin
        last_mem[wr_ptr - AW'(1)] <= 1'b1;
      end
      rd_ptr   <= rd_ptr + AW'(pop);
      wr_ptr   <= wr_ptr + AW'(n_wr);
      count    <= count_next;
      overflow <= overflow | ovf_set;
    end
  end

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      block_done <= 1'b0;
    end else begin
      block_done <= zero_done;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= SEND;
            idx        <= 2'd0;
            byte_out   <= head_word[31:24];
            byte_valid <= 1'b1;
          end
        end
        SEND, STUFF: begin
          if (accept && need_stuff) begin
            state    <= STUFF;
            byte_out <= 8'h00;
          end else if (advance) begin
            if (last_idx) begin
              idx <= 2'd0;
              if (head_last) block_done <= 1'b1;
              // Only entries already resident can be forwarded straight into SEND.
              if (count > CW'(1)) begin
                state    <= SEND;
                byte_out <= next_word[31:24];
              end else begin
                state      <= IDLE;
                byte_out   <= 8'h00;
                byte_valid <= 1'b0;
              end
            end else begin
              idx      <= idx + 2'd1;
              state    <= SEND;
              byte_out <= pick_byte(head_word, idx + 2'd1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          byte_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr_byte_stuffer.sv
// Bench for cr_byte_stuffer: directed scenarios plus random traffic against a byte-queue model.
module tb_cr_byte_stuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_ready;
  logic [31:0] JPEG_bitstream;
  logic        eob_flush;
  logic [31:0] flush_bits;
  logic [4:0]  flush_count;
  logic        byte_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        block_done;
  logic        overflow;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  cr_byte_stuffer #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_ready     (data_ready),
    .JPEG_bitstream (JPEG_bitstream),
    .eob_flush      (eob_flush),
    .flush_bits     (flush_bits),
    .flush_count    (flush_count),
    .byte_ready     (byte_ready),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .block_done     (block_done),
    .overflow       (overflow),
    .fifo_count     (fifo_count)
  );

  typedef struct {
    logic [7:0] b;
    bit         done;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         done_expected = 0;
  int         done_seen = 0;
  bit         done_due = 0;
  bit         mon_en = 0;
  bit         hold = 0;
  logic [7:0] hold_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected byte stream of one FIFO entry: each byte, plus 0x00 after any 0xFF.
  task automatic model_entry(input logic [31:0] w, input int nb, input bit last);
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      logic [7:0] b;
      bit fin;
      b = w[31-8*i -: 8];
      fin = last && (i == nb - 1);
      e.b = b;
      e.done = (b == 8'hFF) ? 1'b0 : fin;
      exp_q.push_back(e);
      if (b == 8'hFF) begin
        e.b = 8'h00;
        e.done = fin;
        exp_q.push_back(e);
      end
    end
    if (last) done_expected++;
  endtask

  task automatic model_flush(input logic [31:0] bits, input int n);
    logic [31:0] w;
    w = bits;
    for (int k = 0; k < 32 - n; k++) w[k] = 1'b1;
    model_entry(w, (n + 7) / 8, 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_data(input logic [31:0] w, input bit model);
    data_ready = 1'b1;
    JPEG_bitstream = w;
    if (model) model_entry(w, 4, 1'b0);
    cyc();
    data_ready = 1'b0;
  endtask

  task automatic write_flush(input logic [31:0] bits, input int n);
    bit empty_zero;
    empty_zero = (n == 0) && (exp_q.size() == 0);
    eob_flush = 1'b1;
    flush_bits = bits;
    flush_count = 5'(n);
    if (n != 0) model_flush(bits, n);
    else if (empty_zero) done_expected++;
    else begin
      exp_q[exp_q.size()-1].done = 1'b1;
      done_expected++;
    end
    cyc();
    eob_flush = 1'b0;
    if (empty_zero) check("zero_flush_done", block_done, 1'b1);
  endtask

  task automatic write_pair(input logic [31:0] w, input logic [31:0] bits, input int n, input bit keep_flush);
    data_ready = 1'b1;
    JPEG_bitstream = w;
    eob_flush = 1'b1;
    flush_bits = bits;
    flush_count = 5'(n);
    model_entry(w, 4, n == 0);
    if (n != 0 && keep_flush) model_flush(bits, n);
    cyc();
    data_ready = 1'b0;
    eob_flush = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || byte_valid || done_due) && n < 3000) begin
      byte_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc();
      n++;
    end
    byte_ready = 1'b1;
    check("drain_timeout", n < 3000, 1'b1);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    return w;
  endfunction

  always @(negedge clk) begin
    if (block_done) done_seen++;
    if (mon_en) begin
      if (done_due) begin
        check("block_done", block_done, 1'b1);
        done_due = 0;
      end
      if (hold) check("hold_stable", {byte_valid, byte_out}, {1'b1, hold_byte});
      hold = byte_valid && !byte_ready;
      hold_byte = byte_out;
      if (byte_valid && byte_ready) begin
        check("byte_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte_out", byte_out, e.b);
          if (e.done) done_due = 1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    data_ready = 1'b0;
    eob_flush = 1'b0;
    JPEG_bitstream = '0;
    flush_bits = '0;
    flush_count = '0;
    byte_ready = 1'b1;
    repeat (2) cyc();
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_done", block_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    rst = 1'b0;
    cyc();
    mon_en = 1;

    write_data(32'h12345678, 1);
    check("lat_k_valid", byte_valid, 1'b0);
    check("lat_k_count", fifo_count, 3'd1);
    cyc();
    check("lat_k1_valid", byte_valid, 1'b1);
    check("lat_k1_byte", byte_out, 8'h12);
    repeat (3) cyc();
    check("lat_k4_byte", {byte_valid, byte_out}, {1'b1, 8'h78});
    drain(0);
    check("count_empty", fifo_count, 3'd0);

    write_data(32'hFF00FFAB, 1);
    drain(0);

    write_flush(32'hA0000000, 3);
    drain(0);
    write_flush(32'hFF000000, 8);
    drain(0);

    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_data(32'hA1B2C3D4 ^ i, i < 4);
    check("full_count", fifo_count, 3'd4);
    check("full_overflow", overflow, 1'b1);
    drain(0);
    check("overflow_sticky", overflow, 1'b1);

    write_pair(32'h11223344, 32'hC0000000, 2, 1);
    drain(0);

    write_flush(32'h0, 0);
    drain(0);
    write_pair(32'h55667788, 32'h0, 0, 0);
    drain(0);
    byte_ready = 1'b0;
    write_data(32'h9ABCDEF0, 1);
    write_flush(32'h0, 0);
    drain(0);

    mon_en = 0;
    hold = 0;
    done_due = 0;
    byte_ready = 1'b0;
    write_data(32'hFFAABBCC, 0);
    cyc();
    check("pre_rst_ff", {byte_valid, byte_out}, {1'b1, 8'hFF});
    byte_ready = 1'b1;
    cyc();
    byte_ready = 1'b0;
    check("pre_rst_stuff", {byte_valid, byte_out}, {1'b1, 8'h00});
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_valid", byte_valid, 1'b0);
    check("mid_rst_count", fifo_count, 3'd0);
    check("mid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    mon_en = 1;
    byte_ready = 1'b1;
    write_data(32'h01020304, 1);
    drain(0);

    byte_ready = 1'b0;
    write_data(32'h10203040, 1);
    write_data(32'h50607080, 1);
    write_data(32'h0A0B0C0D, 1);
    write_pair(32'h21324354, 32'h80000000, 1, 0);
    check("pair_partial_count", fifo_count, 3'd4);
    check("pair_partial_overflow", overflow, 1'b1);
    drain(0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: write_data(rnd_word(), 1);
        1: write_flush(rnd_word(), int'($urandom_range(1, 31)));
        2: write_pair(rnd_word(), rnd_word(), int'($urandom_range(1, 31)), 1);
        default: write_flush(32'h0, 0);
      endcase
      drain(1);
    end

    repeat (2) cyc();
    check("block_done_total", done_seen, done_expected);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
